// File: rtl/pro_pkg.sv
// Shared definitions for the program-load controller: state encoding and default widths.
package pro_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PARK  = 3'd2,
        ST_ARMED = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/prog_load_ctrl_run_budget_cnt.sv
// Saturating run-cycle counter with a limit latched on run entry; flags the final budgeted cycle.
module run_budget_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit_in,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] limit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            limit <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
            limit <= limit_in;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Compare one bit wider so a saturated count can never alias onto the limit.
    assign terminal = (limit != '0) &&
                      (({1'b0, count} + (CNT_W+1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/prog_load_ctrl.sv
// Streams a program into instruction memory from address 0, parks the bus, then runs the
// core until halt or until the optional cycle budget is spent.
module prog_load_ctrl
    import pro_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int AUTO_RUN = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_req,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_budget,
    input  logic              halt_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              working,
    output logic [ADDR_W:0]   words_loaded,
    output logic [CNT_W-1:0]  cycles_run,
    output logic              done,
    output logic              timeout,
    output logic              err
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    state_t state;
    logic   beat;
    logic   cnt_clear;
    logic   cnt_load;
    logic   cnt_en;
    logic   cnt_term;

    assign beat = s_valid && s_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        if (!abort) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: cnt_clear = load_req;
                ST_PARK:                  cnt_load  = (AUTO_RUN != 0);
                ST_ARMED:                 cnt_load  = start;
                ST_RUN:                   cnt_en    = 1'b1;
                default:                  ;
            endcase
        end
    end

    run_budget_cnt #(
        .CNT_W (CNT_W)
    ) u_budget (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .en       (cnt_en),
        .limit_in (run_budget),
        .count    (cycles_run),
        .terminal (cnt_term)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            s_ready      <= 1'b0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            working      <= 1'b0;
            words_loaded <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            err          <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                s_ready <= 1'b0;
                working <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (load_req) begin
                            state        <= ST_LOAD;
                            s_ready      <= 1'b1;
                            words_loaded <= '0;
                            done         <= 1'b0;
                            timeout      <= 1'b0;
                            err          <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        if (beat) begin
                            mem_wr       <= 1'b1;
                            mem_addr     <= words_loaded[ADDR_W-1:0];
                            mem_wdata    <= s_data;
                            words_loaded <= words_loaded + (ADDR_W+1)'(1);
                            if (s_last) begin
                                state   <= ST_PARK;
                                s_ready <= 1'b0;
                            end else if (words_loaded == LAST_ADDR) begin
                                state   <= ST_ERR;
                                s_ready <= 1'b0;
                                err     <= 1'b1;
                            end
                        end
                    end
                    ST_PARK: begin
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        working   <= (AUTO_RUN != 0);
                        state     <= (AUTO_RUN != 0) ? ST_RUN : ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (start) begin
                            state   <= ST_RUN;
                            working <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Halt takes precedence, so a coincident budget expiry is not a timeout.
                        if (halt_in || cnt_term) begin
                            state   <= ST_DONE;
                            working <= 1'b0;
                            done    <= 1'b1;
                            timeout <= !halt_in;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: table-driven load/run vectors plus a write scoreboard.
module tb_prog_load_ctrl;
    import pro_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              load_req;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  run_budget;
    logic              halt_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic              working;
    logic [ADDR_W:0]   words_loaded;
    logic [CNT_W-1:0]  cycles_run;
    logic              done;
    logic              timeout;
    logic              err;

    prog_load_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .AUTO_RUN (0)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_req     (load_req),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .start        (start),
        .abort        (abort),
        .run_budget   (run_budget),
        .halt_in      (halt_in),
        .mem_addr     (mem_addr),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .working      (working),
        .words_loaded (words_loaded),
        .cycles_run   (cycles_run),
        .done         (done),
        .timeout      (timeout),
        .err          (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                exp_addr;
    } beat_t;

    typedef struct {
        logic [CNT_W-1:0] budget;
        int               halt_at;
        int               exp_cycles;
        logic             exp_timeout;
    } run_vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    beat_t    beats[5];
    run_vec_t runs[5];
    wr_t      sb_q[$];
    wr_t      mon_e;
    int       passed = 0;
    int       total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Presents one beat, waits (bounded) for ready, and returns just after the accepting edge.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input int addr);
        wr_t e;
        int  n;
        e.addr = addr[ADDR_W-1:0];
        e.data = d;
        sb_q.push_back(e);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait_bound", 64'(n < 20), 64'(1));
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // One-word program; leaves the controller in ARMED.
    task automatic reload_one(input logic [DATA_W-1:0] d);
        pulse_load_req();
        send_beat(d, 1'b1, 0);
        tick();
        check("reload_words", 64'(words_loaded), 64'(1));
    endtask

    task automatic do_run(input run_vec_t rv);
        int wcount;
        int n;
        run_budget = rv.budget;
        start = 1'b1;
        tick();
        start = 1'b0;
        wcount = 0;
        n = 0;
        while (working === 1'b1 && n < 200) begin
            wcount++;
            n++;
            halt_in = (rv.halt_at != 0) && (wcount == rv.halt_at);
            tick();
        end
        halt_in = 1'b0;
        check("run_working_cycles", 64'(wcount), 64'(rv.exp_cycles));
        check("run_cycles_run", 64'(cycles_run), 64'(rv.exp_cycles));
        check("run_done", 64'(done), 64'(1));
        check("run_timeout", 64'(timeout), 64'(rv.exp_timeout));
    endtask

    // Write scoreboard: every mem_wr pulse must match the oldest outstanding expected write.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && mem_wr === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(mem_wr), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beats[0] = '{32'h10f00010, 1'b0, 0};
        beats[1] = '{32'h20010000, 1'b0, 1};
        beats[2] = '{32'h21230000, 1'b0, 2};
        beats[3] = '{32'h22450000, 1'b0, 3};
        beats[4] = '{32'h23670000, 1'b1, 4};

        runs[0] = '{16'd7, 0,  7,  1'b1};
        runs[1] = '{16'd3, 3,  3,  1'b0};
        runs[2] = '{16'd0, 40, 40, 1'b0};
        runs[3] = '{16'd1, 0,  1,  1'b1};
        runs[4] = '{16'd5, 2,  2,  1'b0};

        reset_n = 1'b0;
        load_req = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        start = 1'b0; abort = 1'b0; run_budget = '0; halt_in = 1'b0;
        tick();
        tick();
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_mem", 64'({mem_addr, mem_wr, mem_wdata}), 64'(0));
        check("rst_working", 64'(working), 64'(0));
        check("rst_counters", 64'({words_loaded, cycles_run}), 64'(0));
        check("rst_flags", 64'({done, timeout, err}), 64'(0));
        reset_n = 1'b1;
        tick();

        // Contiguous load of five words, then the parked bus and ARMED state.
        pulse_load_req();
        for (int i = 0; i < 5; i++) send_beat(beats[i].data, beats[i].last, beats[i].exp_addr);
        tick();
        check("park_bus", 64'({mem_addr, mem_wr, mem_wdata}), 64'(0));
        check("park_s_ready", 64'(s_ready), 64'(0));
        check("load_words", 64'(words_loaded), 64'(5));
        check("load_sb_drained", 64'(sb_q.size()), 64'(0));
        check("state_armed", 64'(dut.state), 64'(ST_ARMED));

        // Run vectors; the first uses the program already armed.
        for (int r = 0; r < 5; r++) begin
            if (r != 0) reload_one(32'h0000_0100 + 32'(r));
            do_run(runs[r]);
            if (r == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                tick();
                check("done_ignores_start", 64'(working), 64'(0));
            end
        end

        // Same program with s_valid dropped between beats.
        pulse_load_req();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b0;
            tick();
            send_beat(beats[i].data, beats[i].last, beats[i].exp_addr);
        end
        tick();
        check("gap_words", 64'(words_loaded), 64'(5));
        check("gap_sb_drained", 64'(sb_q.size()), 64'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_armed_idle", 64'(dut.state), 64'(ST_IDLE));

        // Overflow: sixteen words without s_last fill memory and raise err.
        pulse_load_req();
        check("load_req_clears_words", 64'(words_loaded), 64'(0));
        for (int i = 0; i < 16; i++) send_beat(32'hA500_0000 + 32'(i), 1'b0, i);
        check("ovf_err", 64'(err), 64'(1));
        check("ovf_s_ready", 64'(s_ready), 64'(0));
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (3) tick();
        s_valid = 1'b0;
        check("ovf_words", 64'(words_loaded), 64'(16));
        check("ovf_state_err", 64'(dut.state), 64'(ST_ERR));
        pulse_load_req();
        check("ovf_err_cleared", 64'(err), 64'(0));
        send_beat(32'h5A5A_0001, 1'b1, 0);
        tick();
        check("ovf_restart_sb", 64'(sb_q.size()), 64'(0));

        // Abort coinciding with the third beat of a load.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pulse_load_req();
        send_beat(beats[0].data, 1'b0, 0);
        send_beat(beats[1].data, 1'b0, 1);
        s_valid = 1'b1;
        s_data  = beats[2].data;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_load_mem_wr", 64'(mem_wr), 64'(0));
        check("abort_load_ready", 64'(s_ready), 64'(0));
        check("abort_load_working", 64'(working), 64'(0));
        check("abort_load_state", 64'(dut.state), 64'(ST_IDLE));
        check("abort_load_words", 64'(words_loaded), 64'(2));
        tick();

        // Asynchronous reset in the middle of an unbounded run.
        reload_one(32'h0BAD_F00D);
        run_budget = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_working", 64'(working), 64'(1));
        reset_n = 1'b0;
        #1;
        check("rst_run_working", 64'(working), 64'(0));
        check("rst_run_mem", 64'({mem_addr, mem_wr, mem_wdata}), 64'(0));
        check("rst_run_counters", 64'({words_loaded, cycles_run}), 64'(0));
        check("rst_run_flags", 64'({s_ready, done, timeout, err}), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        check("final_sb_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
